// File: rtl/lb_pkg.sv
// Shared line-buffer definitions for the reader (and future writer-side blocks).
package lb_pkg;
  localparam int unsigned LB_LINE_W  = 28;
  localparam int unsigned LB_ADDR_W  = 7;
  localparam int unsigned LB_PIX_W   = 8;
  localparam int unsigned LB_WIN_PIX = 3;
  localparam int unsigned LB_WIN_W   = LB_PIX_W * LB_WIN_PIX;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_HI,
    HOLD
  } lb_state_e;
endpackage

// File: rtl/lb_watchdog.sv
// Load/count/expire counter: cleared by load, advances while count is high,
// saturates at TIMEOUT and reports expired from then on.
module lb_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT));

  // Cycle counter; load wins over count, and counting stops at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lb_window_reader.sv
// Read-side initiator for the line buffer: walks the window start address with
// a fixed stride, fetches each 3-pixel window and presents it on a valid/ready
// stream. A watchdog aborts the line if the buffer never answers.
module lb_window_reader
  import lb_pkg::*;
#(
  parameter int unsigned LINE_W  = LB_LINE_W,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_en,
  input  logic                 lb_full,
  input  logic                 lb_data_valid,
  input  logic [LB_WIN_W-1:0]  lb_rd_data,
  output logic                 lb_rd_en,
  output logic [LB_ADDR_W-1:0] lb_rd_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LB_WIN_W-1:0]  out_data,
  output logic [LB_ADDR_W-1:0] out_col,
  output logic                 out_last,
  output logic                 line_done,
  output logic                 err_timeout
);
  lb_state_e            state;
  logic [LB_ADDR_W-1:0] col;
  logic [LB_ADDR_W:0]   col_nxt;
  logic                 last_win;
  logic                 wd_load;
  logic                 wd_count;
  logic                 wd_exp;

  // One extra bit so the last-window compare cannot wrap.
  assign col_nxt  = {1'b0, col} + (LB_ADDR_W + 1)'(STRIDE);
  assign last_win = (col_nxt > (LB_ADDR_W + 1)'(LINE_W - 3));
  assign wd_count = (state == REQ) || (state == WAIT_HI);

  // Watchdog clear: held in the non-counting states, and pulsed on the exact
  // edges that leave REQ or WAIT_HI, so each counting state starts from zero.
  always_comb begin
    wd_load = 1'b1;
    unique case (state)
      IDLE:    wd_load = 1'b1;
      REQ:     wd_load = !lb_data_valid;
      WAIT_HI: wd_load = lb_data_valid;
      HOLD:    wd_load = 1'b1;
      default: wd_load = 1'b1;
    endcase
  end

  lb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .count  (wd_count),
    .expired(wd_exp)
  );

  // Scan FSM with registered read request and output window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      lb_rd_en    <= 1'b0;
      lb_rd_addr  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      line_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      line_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_en && lb_full) begin
            lb_rd_addr <= col;
            lb_rd_en   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (wd_exp) begin
            err_timeout <= 1'b1;
            lb_rd_en    <= 1'b0;
            col         <= '0;
            state       <= IDLE;
          end else if (!lb_data_valid) begin
            // Buffer has accepted; drop the request before its next idle cycle.
            lb_rd_en <= 1'b0;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (wd_exp) begin
            err_timeout <= 1'b1;
            lb_rd_en    <= 1'b0;
            col         <= '0;
            state       <= IDLE;
          end else if (lb_data_valid) begin
            out_data  <= lb_rd_data;
            out_col   <= col;
            out_last  <= last_win;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              col       <= '0;
              line_done <= 1'b1;
              state     <= IDLE;
            end else begin
              col        <= col_nxt[LB_ADDR_W-1:0];
              lb_rd_addr <= col_nxt[LB_ADDR_W-1:0];
              lb_rd_en   <= 1'b1;
              state      <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lb_window_reader.sv
// Bench for lb_window_reader: lane 0 runs STRIDE=1, lane 1 runs STRIDE=3, each
// against a behavioural line-buffer model holding pixels 0x00..0x1B.
module tb_lb_window_reader;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_en = 1'b0;
  logic        lb_full   [2];
  logic        lb_dv     [2];
  logic [23:0] lb_data   [2];
  logic        rd_en     [2];
  logic [6:0]  rd_addr   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [23:0] out_data  [2];
  logic [6:0]  out_col   [2];
  logic        out_last  [2];
  logic        line_done [2];
  logic        err       [2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lb_window_reader dut0 (
    .clk(clk), .rst(rst), .start_en(start_en), .lb_full(lb_full[0]),
    .lb_data_valid(lb_dv[0]), .lb_rd_data(lb_data[0]), .lb_rd_en(rd_en[0]),
    .lb_rd_addr(rd_addr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_col(out_col[0]), .out_last(out_last[0]),
    .line_done(line_done[0]), .err_timeout(err[0])
  );

  lb_window_reader #(.STRIDE(3)) dut1 (
    .clk(clk), .rst(rst), .start_en(start_en), .lb_full(lb_full[1]),
    .lb_data_valid(lb_dv[1]), .lb_rd_data(lb_data[1]), .lb_rd_en(rd_en[1]),
    .lb_rd_addr(rd_addr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_col(out_col[1]), .out_last(out_last[1]),
    .line_done(line_done[1]), .err_timeout(err[1])
  );

  // Line-buffer model: accept in an idle cycle, valid low next edge, data and
  // valid high the edge after. After reset valid is left high with stale data.
  int         load_tok  [2];
  int         seen_tok  [2];
  int         accepts   [2];
  bit         bbusy     [2];
  logic [6:0] baddr     [2];
  bit         dead      [2];
  bit         drop_en   [2];
  logic [6:0] drop_addr [2];

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        bbusy[g]    <= 1'b0;
        lb_dv[g]    <= 1'b1;
        lb_data[g]  <= 24'hDEADBE;
        lb_full[g]  <= 1'b0;
        dead[g]     <= 1'b0;
        seen_tok[g] <= load_tok[g];
      end else begin
        if (load_tok[g] != seen_tok[g]) begin
          lb_full[g]  <= 1'b1;
          seen_tok[g] <= load_tok[g];
        end
        if (!bbusy[g] && rd_en[g]) begin
          accepts[g] <= accepts[g] + 1;
          lb_full[g] <= 1'b0;
          baddr[g]   <= rd_addr[g];
          dead[g]    <= drop_en[g] && (rd_addr[g] == drop_addr[g]);
          lb_dv[g]   <= 1'b0;
          bbusy[g]   <= 1'b1;
        end else if (bbusy[g]) begin
          bbusy[g] <= 1'b0;
          if (!dead[g]) begin
            lb_dv[g]   <= 1'b1;
            lb_data[g] <= {1'b0, baddr[g] + 7'd2, 1'b0, baddr[g] + 7'd1, 1'b0, baddr[g]};
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d: got %0h want %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Stream model state: window k of a line starts at k*STRIDE.
  int          idx       [2];
  bit          done_pend [2];
  bit          stalled   [2];
  logic [23:0] sv_data   [2];
  logic [6:0]  sv_col    [2];
  logic        sv_last   [2];
  int          hs_cnt    [2];
  int          done_cnt  [2];
  bit          got_first [2];
  logic [23:0] first_data[2];
  logic [6:0]  last_col  [2];

  task automatic check_cycle();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      int s;
      int nw;
      int c;
      logic [23:0] exp_w;
      s  = (g == 0) ? 1 : 3;
      nw = 25 / s + 1;
      if (rst) begin
        idx[g] = 0; done_pend[g] = 0; stalled[g] = 0; got_first[g] = 0;
        continue;
      end
      chk("line_done", g, line_done[g], done_pend[g]);
      if (line_done[g]) done_cnt[g]++;
      done_pend[g] = 0;
      if (out_valid[g]) begin
        chk("rd_en_while_valid", g, rd_en[g], 0);
        if (stalled[g]) begin
          chk("stall_data", g, out_data[g], sv_data[g]);
          chk("stall_col", g, out_col[g], sv_col[g]);
          chk("stall_last", g, out_last[g], sv_last[g]);
        end
        if (out_ready[g]) begin
          c     = idx[g] * s;
          exp_w = {8'(c + 2), 8'(c + 1), 8'(c)};
          chk("win_data", g, out_data[g], exp_w);
          chk("win_col", g, out_col[g], 7'(c));
          chk("win_last", g, out_last[g], idx[g] == nw - 1);
          hs_cnt[g]++;
          last_col[g] = out_col[g];
          if (!got_first[g]) begin
            first_data[g] = out_data[g];
            got_first[g]  = 1;
          end
          if (idx[g] == nw - 1) begin
            idx[g] = 0;
            done_pend[g] = 1;
          end else begin
            idx[g]++;
          end
          stalled[g] = 0;
        end else begin
          stalled[g] = 1;
          sv_data[g] = out_data[g];
          sv_col[g]  = out_col[g];
          sv_last[g] = out_last[g];
        end
      end else begin
        stalled[g] = 0;
      end
    end
  endtask

  task automatic wait_done(input int g, input int d0, input bit rnd);
    int n = 0;
    int stall = 0;
    while (done_cnt[g] == d0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (rnd) begin
        if (stall > 0) begin
          out_ready[g] = 1'b0;
          stall--;
        end else begin
          out_ready[g] = 1'b1;
          stall = $urandom_range(0, 7);
        end
      end
    end
    out_ready[g] = 1'b1;
    chk("line_bound", g, n < 3000, 1);
  endtask

  task automatic wait_req_drop(input logic [6:0] a);
    int n = 0;
    bit found = 0;
    logic p;
    p = rd_en[0];
    while (!found && n < 2000) begin
      @(posedge clk); #1;
      n++;
      found = p && !rd_en[0] && (rd_addr[0] == a);
      p = rd_en[0];
    end
    chk("req_seen", 0, found, 1);
  endtask

  task automatic check_all_zero(input string name);
    for (int g = 0; g < 2; g++) begin
      chk({name, "_rd_en"}, g, rd_en[g], 0);
      chk({name, "_rd_addr"}, g, rd_addr[g], 0);
      chk({name, "_valid"}, g, out_valid[g], 0);
      chk({name, "_data"}, g, out_data[g], 0);
      chk({name, "_col"}, g, out_col[g], 0);
      chk({name, "_last"}, g, out_last[g], 0);
      chk({name, "_done"}, g, line_done[g], 0);
      chk({name, "_err"}, g, err[g], 0);
    end
  endtask

  initial begin
    int h0, h1, a0, a1, d0, d1, lat;
    for (int g = 0; g < 2; g++) begin
      out_ready[g] = 1'b1;
      drop_en[g]   = 1'b0;
      drop_addr[g] = '0;
    end
    fork
      forever check_cycle();
    join_none

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    // Full line on both lanes, stale valid high at start, ready held high.
    start_en = 1'b1;
    h0 = hs_cnt[0]; a0 = accepts[0]; d0 = done_cnt[0];
    h1 = hs_cnt[1]; a1 = accepts[1]; d1 = done_cnt[1];
    load_tok[0]++; load_tok[1]++;
    wait_done(0, d0, 0);
    wait_done(1, d1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("windows", 0, hs_cnt[0] - h0, 26);
    chk("accepts", 0, accepts[0] - a0, 26);
    chk("done_pulses", 0, done_cnt[0] - d0, 1);
    chk("last_col", 0, last_col[0], 25);
    chk("first_window", 0, first_data[0], 24'h020100);
    chk("windows", 1, hs_cnt[1] - h1, 9);
    chk("accepts", 1, accepts[1] - a1, 9);
    chk("done_pulses", 1, done_cnt[1] - d1, 1);
    chk("last_col", 1, last_col[1], 24);
    chk("first_window", 1, first_data[1], 24'h020100);

    // start_en low holds off a full buffer; then random backpressure.
    start_en = 1'b0;
    h0 = hs_cnt[0]; a0 = accepts[0]; d0 = done_cnt[0];
    load_tok[0]++;
    repeat (10) @(posedge clk);
    #1 chk("no_start", 0, accepts[0] - a0, 0);
    start_en = 1'b1;
    wait_done(0, d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("windows_stall", 0, hs_cnt[0] - h0, 26);
    chk("accepts_stall", 0, accepts[0] - a0, 26);
    chk("done_stall", 0, done_cnt[0] - d0, 1);

    // Buffer never answers the read at col 5.
    drop_en[0] = 1'b1; drop_addr[0] = 7'd5;
    load_tok[0]++;
    wait_req_drop(7'd5);
    lat = 0;
    while (!err[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("timeout_latency", 0, lat, TIMEOUT + 1);
    chk("timeout_rd_en", 0, rd_en[0], 0);
    chk("timeout_valid", 0, out_valid[0], 0);
    repeat (6) @(posedge clk);
    #1;
    chk("err_sticky", 0, err[0], 1);
    chk("idle_rd_en", 0, rd_en[0], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("err_cleared", 0, err[0], 0);
    rst = 1'b0;

    // Asynchronous reset in the middle of WAIT_HI at col 10.
    drop_addr[0] = 7'd10;
    load_tok[0]++;
    wait_req_drop(7'd10);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    drop_en[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    h0 = hs_cnt[0]; a0 = accepts[0]; d0 = done_cnt[0];
    load_tok[0]++;
    wait_done(0, d0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("windows_restart", 0, hs_cnt[0] - h0, 26);
    chk("accepts_restart", 0, accepts[0] - a0, 26);
    chk("first_restart", 0, first_data[0], 24'h020100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
